// File: rtl/coord_scatter_queue.sv
// coord_scatter_queue: takes one group of up to LANES candidate (row, col, product)
// triples and drops lanes that are masked off or fall outside the out_dim x out_dim
// plane. It then emits each surviving lane, lowest index first and one per cycle, as
// a linear accumulator address plus bank select.
// Optional build macro: COORD_SCATTER_STATS_EN adds the drop/emit counters and stats_clear.
module coord_scatter_queue #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned PW        = 24,
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned ADDR_W    = 18,
    localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*16-1:0]   in_row,
    input  logic [LANES*16-1:0]   in_col,
    input  logic [LANES*PW-1:0]   in_product,
    input  logic [LANES-1:0]      in_mask,
    input  logic [8:0]            out_dim,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [BANK_W-1:0]     out_bank,
    output logic [PW-1:0]         out_product,
    output logic                  group_done,
    output logic                  busy
`ifdef COORD_SCATTER_STATS_EN
    ,
    input  logic                  stats_clear,
    output logic [31:0]           drop_count,
    output logic [31:0]           emit_count
`endif
);

    localparam int unsigned SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]          state, state_nxt;
    logic [LANES-1:0]    keep, keep_nxt, keep_in, inbound;
    logic [LANES*16-1:0] row_q, col_q;
    logic [LANES*PW-1:0] prod_q;
    logic                accept, hs, load, group_done_nxt;
    logic [15:0]         dim16;
    logic [SEL_W-1:0]    sel;
    logic [15:0]         lane_row, lane_col;
    logic [PW-1:0]       lane_prod;
    logic [ADDR_W-1:0]   lane_addr;

    assign accept = in_valid & in_ready;
    assign hs     = out_valid & out_ready;
    assign dim16  = 16'(out_dim);
    assign keep_in = in_mask & inbound;
    assign load   = (accept | hs) & (keep_nxt != '0);

    // Per-lane bounds check: a clear sign bit makes the unsigned compare equal the signed one
    always_comb begin
        inbound = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            inbound[i] = ~in_row[i*16+15] & (in_row[i*16 +: 16] < dim16)
                       & ~in_col[i*16+15] & (in_col[i*16 +: 16] < dim16);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state, next keep mask and completion pulse
    always_comb begin
        state_nxt      = state;
        keep_nxt       = keep;
        group_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    keep_nxt = keep_in;
                    if (keep_in == '0) group_done_nxt = 1'b1;
                    else               state_nxt      = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hs) begin
                    keep_nxt = keep & (keep - LANES'(1));
                    if (keep_nxt == '0) begin
                        group_done_nxt = 1'b1;
                        state_nxt      = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lowest set lane of the upcoming keep mask, sourced from the inputs on accept
    always_comb begin
        sel = '0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (keep_nxt[i]) sel = SEL_W'(i);
        end
        lane_row  = accept ? in_row[sel*16 +: 16]     : row_q[sel*16 +: 16];
        lane_col  = accept ? in_col[sel*16 +: 16]     : col_q[sel*16 +: 16];
        lane_prod = accept ? in_product[sel*PW +: PW] : prod_q[sel*PW +: PW];
        lane_addr = ADDR_W'(lane_row) * ADDR_W'(out_dim) + ADDR_W'(lane_col);
    end

    // Lane storage and registered outputs; the next entry is pre-computed so it lines up with out_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keep        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            prod_q      <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            group_done  <= 1'b0;
            out_addr    <= '0;
            out_bank    <= '0;
            out_product <= '0;
        end else begin
            keep       <= keep_nxt;
            in_ready   <= (state_nxt == S_IDLE);
            busy       <= (state_nxt == S_SCAN);
            out_valid  <= (keep_nxt != '0);
            group_done <= group_done_nxt;
            if (accept) begin
                row_q  <= in_row;
                col_q  <= in_col;
                prod_q <= in_product;
            end
            if (load) begin
                out_addr    <= lane_addr;
                out_bank    <= lane_addr[BANK_W-1:0];
                out_product <= lane_prod;
            end
        end
    end

`ifdef COORD_SCATTER_STATS_EN
    logic [31:0] drop_inc;

    // Number of requested lanes that fail the bounds check in the offered group
    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            drop_inc = drop_inc + 32'(in_mask[i] & ~inbound[i]);
        end
    end

    // Wrapping statistics counters; clear wins over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
            emit_count <= '0;
        end else if (stats_clear) begin
            drop_count <= '0;
            emit_count <= '0;
        end else begin
            if (accept) drop_count <= drop_count + drop_inc;
            if (hs)     emit_count <= emit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coord_scatter_queue.sv
// Directed bench for coord_scatter_queue with hand-computed expected addresses.
module tb_coord_scatter_queue;

    localparam int unsigned LANES  = 16;
    localparam int unsigned PW     = 24;
    localparam int unsigned NB     = 8;
    localparam int unsigned ADDR_W = 18;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*16-1:0]   in_row;
    logic [LANES*16-1:0]   in_col;
    logic [LANES*PW-1:0]   in_product;
    logic [LANES-1:0]      in_mask;
    logic [8:0]            out_dim;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_addr;
    logic [2:0]            out_bank;
    logic [PW-1:0]         out_product;
    logic                  group_done;
    logic                  busy;
`ifdef COORD_SCATTER_STATS_EN
    logic                  stats_clear;
    logic [31:0]           drop_count;
    logic [31:0]           emit_count;
`endif

    int errors = 0;
    int checks = 0;

    coord_scatter_queue #(
        .LANES(LANES), .PW(PW), .NUM_BANKS(NB), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_col(in_col), .in_product(in_product), .in_mask(in_mask),
        .out_dim(out_dim),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_bank(out_bank), .out_product(out_product),
        .group_done(group_done), .busy(busy)
`ifdef COORD_SCATTER_STATS_EN
        , .stats_clear(stats_clear), .drop_count(drop_count), .emit_count(emit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes;
        in_row     = '0;
        in_col     = '0;
        in_product = '0;
        in_mask    = '0;
    endtask

    task automatic set_lane(input int i, input logic [15:0] r, input logic [15:0] c,
                            input logic [PW-1:0] p);
        in_row[i*16 +: 16]     = r;
        in_col[i*16 +: 16]     = c;
        in_product[i*PW +: PW] = p;
        in_mask[i]             = 1'b1;
    endtask

    task automatic send_group;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || group_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b group_done=%b busy=%b want 1 0 0 0",
                     in_ready, out_valid, group_done, busy);
        end
        checks++;
        if (out_addr !== '0 || out_bank !== '0 || out_product !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d bank=%0d prod=%0d want 0 0 0",
                     out_addr, out_bank, out_product);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int ea[4] = '{0, 10, 63, 29};
        int eb[4] = '{0, 2, 7, 5};
        logic [PW-1:0] ep[4] = '{24'd11, 24'd22, 24'hFFFFFB, 24'd44};
        clear_lanes();
        out_dim   = 9'd8;
        out_ready = 1'b1;
        set_lane(0, 16'd0, 16'd0, ep[0]);
        set_lane(1, 16'd1, 16'd2, ep[1]);
        set_lane(2, 16'd7, 16'd7, ep[2]);
        set_lane(3, 16'd3, 16'd5, ep[3]);
        send_group();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== ADDR_W'(ea[j]) || out_bank !== 3'(eb[j])
                || out_product !== ep[j] || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_emit%0d: v=%b addr=%0d bank=%0d prod=%h busy=%b rdy=%b want 1 %0d %0d %h 1 0",
                         j, out_valid, out_addr, out_bank, out_product, busy, in_ready, ea[j], eb[j], ep[j]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || group_done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: v=%b done=%b rdy=%b busy=%b want 0 1 1 0",
                     out_valid, group_done, in_ready, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (group_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b want 0", group_done);
        end
        tick();
    endtask

    task automatic test_drop;
        clear_lanes();
        out_dim = 9'd8;
        set_lane(0, 16'hFFFF, 16'd0, 24'd1);
        set_lane(1, 16'd8,    16'd3, 24'd2);
        set_lane(2, 16'd2,    16'hFFFF, 24'd3);
        set_lane(3, 16'd4,    16'd4, 24'd77);
        send_group();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 18'd36 || out_bank !== 3'd4 || out_product !== 24'd77) begin
            errors++;
            $display("FAIL drop_emit: v=%b addr=%0d bank=%0d prod=%0d want 1 36 4 77",
                     out_valid, out_addr, out_bank, out_product);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || group_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_done: v=%b done=%b want 0 1", out_valid, group_done);
        end
`ifdef COORD_SCATTER_STATS_EN
        checks++;
        if (drop_count !== 32'd3 || emit_count !== 32'd5) begin
            errors++;
            $display("FAIL stats_count: drop=%0d emit=%0d want 3 5", drop_count, emit_count);
        end
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (drop_count !== 32'd0 || emit_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear: drop=%0d emit=%0d want 0 0", drop_count, emit_count);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back;
        clear_lanes();
        out_dim  = 9'd8;
        in_valid = 1'b1;
        tick();
        set_lane(1, 16'd2, 16'd2, 24'd55);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || group_done !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_group: v=%b done=%b rdy=%b want 0 1 1", out_valid, group_done, in_ready);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 18'd18 || out_bank !== 3'd2 || out_product !== 24'd55
            || group_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_emit: v=%b addr=%0d bank=%0d prod=%0d done=%b want 1 18 2 55 0",
                     out_valid, out_addr, out_bank, out_product, group_done);
        end
        tick();
        tick();
        clear_lanes();
        set_lane(0, 16'd0, 16'd0, 24'd9);
        out_dim = 9'd0;
        send_group();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || group_done !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL dim_zero: v=%b done=%b rdy=%b want 0 1 1", out_valid, group_done, in_ready);
        end
        out_dim = 9'd8;
        tick();
    endtask

    task automatic test_backpressure;
        clear_lanes();
        out_dim   = 9'd8;
        out_ready = 1'b0;
        set_lane(0, 16'd1, 16'd1, 24'd123);
        set_lane(5, 16'd2, 16'd3, 24'd456);
        send_group();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 18'd9 || out_bank !== 3'd1 || out_product !== 24'd123
                || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b addr=%0d bank=%0d prod=%0d rdy=%b want 1 9 1 123 0",
                         j, out_valid, out_addr, out_bank, out_product, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 18'd19 || out_bank !== 3'd3 || out_product !== 24'd456) begin
            errors++;
            $display("FAIL bp_second: v=%b addr=%0d bank=%0d prod=%0d want 1 19 3 456",
                     out_valid, out_addr, out_bank, out_product);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || group_done !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: v=%b done=%b rdy=%b want 0 1 1", out_valid, group_done, in_ready);
        end
        tick();
    endtask

    task automatic test_max_dim;
        clear_lanes();
        out_dim = 9'd511;
        set_lane(0, 16'd510, 16'd510, 24'd3);
        send_group();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 18'd261120 || out_bank !== 3'd0) begin
            errors++;
            $display("FAIL max_dim: v=%b addr=%0d bank=%0d want 1 261120 0", out_valid, out_addr, out_bank);
        end
        tick();
        out_dim = 9'd8;
        tick();
    endtask

    task automatic test_reset_mid;
        clear_lanes();
        out_dim = 9'd8;
        set_lane(0, 16'd1, 16'd0, 24'd1);
        set_lane(1, 16'd1, 16'd1, 24'd2);
        set_lane(2, 16'd1, 16'd2, 24'd3);
        set_lane(3, 16'd1, 16'd3, 24'd4);
        send_group();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || group_done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet%0d: v=%b done=%b want 0 0", j, out_valid, group_done);
            end
        end
        tick();
        clear_lanes();
        set_lane(6, 16'd6, 16'd5, 24'd66);
        send_group();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 18'd53 || out_bank !== 3'd5 || out_product !== 24'd66) begin
            errors++;
            $display("FAIL post_reset_emit: v=%b addr=%0d bank=%0d prod=%0d want 1 53 5 66",
                     out_valid, out_addr, out_bank, out_product);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || group_done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done: v=%b done=%b want 0 1", out_valid, group_done);
        end
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        out_dim   = 9'd8;
        clear_lanes();
`ifdef COORD_SCATTER_STATS_EN
        stats_clear = 1'b0;
`endif
        test_reset();
        test_basic();
        test_drop();
        test_back_to_back();
        test_backpressure();
        test_max_dim();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coord_scatter_queue.md
Name: coord_scatter_queue

Overview:
Sits directly downstream of the output-coordinate computation stage in the sparse convolution datapath. It accepts one group of up to LANES candidate (row, column, product) triples per handshake. It discards entries that are masked off or fall outside the output plane, and converts each surviving coordinate pair into a linear accumulator address plus bank select. Survivors are then emitted one per cycle to the accumulator buffer through a valid/ready interface.

Parameters:
- LANES, 16, number of candidate lanes per input group; range 1..256.
- PW, 24, product width in bits (signed).
- NUM_BANKS, 8, number of accumulator banks; must be a power of 2.
- ADDR_W, 18, linear output address width; must hold 511*511+510.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input group valid.
- in_ready  out  1  block can accept a group.
- in_row  in  LANES*16  signed row coords; lane i at [16i+15:16i].
- in_col  in  LANES*16  signed column coords; same packing as in_row.
- in_product  in  LANES*PW  signed products; lane i at [PW*i+PW-1:PW*i].
- in_mask  in  LANES  per-lane candidate valid.
- out_dim  in  9  output plane width = height; quasi-static.
- out_valid  out  1  emitted entry valid.
- out_ready  in  1  accumulator accepts entry.
- out_addr  out  ADDR_W  linear address row*out_dim+col.
- out_bank  out  log2(NUM_BANKS)  out_addr modulo NUM_BANKS (low bits).
- out_product  out  PW  product for this address.
- group_done  out  1  one-cycle pulse, group fully drained.
- busy  out  1  a group is held.

Behaviour:
- Reset (async, reset_n low) values:
  - in_ready=1, out_valid=0, group_done=0, busy=0.
  - out_addr, out_bank and out_product all 0.
  - Internal keep-mask and lane registers cleared.
  - Reset mid-group abandons the group; no further emission occurs.
- States: IDLE, SCAN.
  - In IDLE, in_ready=1 and busy=0.
  - In SCAN, in_ready=0 and busy=1.
- Accept: in_valid&&in_ready at edge k.
  - Latch in_row, in_col, in_product and keep = in_mask & inbound.
  - inbound[i] = (row>=0) && (row<out_dim) && (col>=0) && (col<out_dim), using signed compare with out_dim zero-extended.
  - If keep==0: stay IDLE and pulse group_done in cycle k+1. in_ready stays 1, so a back-to-back accept is legal.
  - Else: enter SCAN; out_valid=1 from cycle k+1 (1-cycle latency).
- SCAN:
  - The selected lane is the lowest-index set bit of keep.
  - out_addr = row*out_dim + col on the selected lane, computed from the registered lane, combinationally or pre-registered, but valid in the same cycle as out_valid.
  - Arithmetic is unsigned after the bounds check; the result is truncated to ADDR_W and never overflows for legal inputs.
  - On out_valid&&out_ready: clear the selected keep bit.
    - If it was the last bit: next cycle out_valid=0, group_done=1 for one cycle, state IDLE, in_ready=1.
    - Else: the next-lowest lane is presented next cycle.
  - This gives a throughput of one entry per cycle under continuous out_ready.
  - While out_valid&&!out_ready, out_addr, out_bank and out_product hold stable.
- out_dim must not change while busy; the behaviour if it does is undefined.
- When out_dim==0, every lane is dropped.
- in_valid while busy is ignored, since in_ready=0; upstream must hold.

Optional Feature:
COORD_SCATTER_STATS_EN:
- When defined, adds the following outputs:
  - drop_count (32 bits): counts lanes with in_mask=1 that failed the bounds check, summed per accepted group.
  - emit_count (32 bits): increments on each out handshake.
- Add stats_clear (in, 1): synchronous clear of both counters, which takes priority over an increment in the same cycle.
- Counters wrap modulo 2^32 and reset to 0 on reset_n.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- out_dim=8, lanes 0..3 mask=1 with (0,0),(1,2),(7,7),(3,5), out_ready=1.
  - Required: addrs 0,10,63,29 in cycles k+1..k+4, banks 0,2,7,5.
  - Required: group_done at k+5.
- out_dim=8, lanes (-1,0),(8,3),(2,-1),(4,4) all masked in.
  - Required: only addr 36 (bank 4) emitted.
  - With STATS_EN, drop_count=3.
- in_mask=0 or out_dim=0.
  - Required: out_valid never asserted; group_done pulses at k+1; in_ready stays 1; second group accepted at k+1.
- Backpressure: 2 survivors, out_ready=0 for 3 cycles after out_valid rises.
  - Required: addr/product stable across the 3 cycles; in_ready=0 throughout; drain completes after out_ready goes high.
- out_dim=511, row=510, col=510.
  - Required: out_addr=261120, out_bank=0, no truncation.
- reset_n low mid-SCAN with 3 entries pending.
  - Required: out_valid=0 and in_ready=1 immediately.
  - Required: no group_done; next group processed normally.
